jtag_tap_oversampled: RTL and testbench

- JTAG responder: an IEEE 1149.1 TAP controller that oversamples the external TCK/TMS/TDI/TRSTn pins with the system clock.
- Answers the same bit-level sequences the JTAG host tasks drive: reset, bypass test, IDCODE read, and DMI-style user-DR shifts.
- Sits between the JTAG pads and a debug transport (DMI). Exposes one user data register through a capture/update handshake in the system clock domain, so no TCK clock tree is needed.

---
 rtl/jtag_tap_oversampled.sv | 190 +++++++++++++++++++
 tb/tb_jtag_tap_oversampled.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_oversampled.sv
// IEEE 1149.1 TAP controller that runs entirely in the system clock domain.
// TCK/TMS/TDI/TRSTn are oversampled, and the TAP acts only on detected TCK edges.
module jtag_tap_oversampled #(
  parameter int unsigned          IR_WIDTH    = 5,
  parameter logic [31:0]          IDCODE_VAL  = 32'h10000DB3,
  parameter logic [IR_WIDTH-1:0]  IR_IDCODE   = 5'h01,
  parameter logic [IR_WIDTH-1:0]  IR_USER     = 5'h11,
  parameter int unsigned          DR_WIDTH    = 41,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                jtag_tck_i,
  input  logic                jtag_tms_i,
  input  logic                jtag_tdi_i,
  input  logic                jtag_trst_ni,
  output logic                jtag_tdo_o,
  output logic                jtag_tdo_oe_o,
  output logic [3:0]          tap_state_o,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic                dr_capture_o,
  input  logic [DR_WIDTH-1:0] dr_capture_data_i,
  output logic                dr_update_o,
  output logic [DR_WIDTH-1:0] dr_update_data_o
);

  typedef enum logic [3:0] {
    TLR     = 4'd0,  RTI     = 4'd1,  SEL_DR  = 4'd2,  CAP_DR  = 4'd3,
    SH_DR   = 4'd4,  EX1_DR  = 4'd5,  PAUSE_DR = 4'd6, EX2_DR  = 4'd7,
    UPD_DR  = 4'd8,  SEL_IR  = 4'd9,  CAP_IR  = 4'd10, SH_IR   = 4'd11,
    EX1_IR  = 4'd12, PAUSE_IR = 4'd13, EX2_IR = 4'd14, UPD_IR  = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {SEL_IDCODE, SEL_USER, SEL_BYPASS} dr_sel_e;

  // All four pins travel through the same stages, so TMS/TDI stay aligned with TCK.
  // Bit order per stage: {trst_n, tdi, tms, tck}.
  logic [3:0] pin_sync_q [SYNC_STAGES];
  logic       tck_s, tms_s, tdi_s, trst_n_s;
  logic       tck_prev_q;
  logic       tck_rise, tck_fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) pin_sync_q[i] <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      pin_sync_q[0] <= {jtag_trst_ni, jtag_tdi_i, jtag_tms_i, jtag_tck_i};
      for (int i = 1; i < SYNC_STAGES; i++) pin_sync_q[i] <= pin_sync_q[i-1];
      tck_prev_q <= tck_s;
    end
  end

  assign {trst_n_s, tdi_s, tms_s, tck_s} = pin_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;

  tap_state_e          state_q, state_d, state_nxt;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [31:0]         idcode_sr_q, idcode_sr_d;
  logic [DR_WIDTH-1:0] user_sr_q, user_sr_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic                capture, update;
  dr_sel_e             dr_sel;

  assign dr_sel = (ir_q == IR_IDCODE) ? SEL_IDCODE :
                  (ir_q == IR_USER)   ? SEL_USER   : SEL_BYPASS;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TLR:      state_nxt = tms_s ? TLR      : RTI;
      RTI:      state_nxt = tms_s ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms_s ? EX1_DR   : SH_DR;
      SH_DR:    state_nxt = tms_s ? EX1_DR   : SH_DR;
      EX1_DR:   state_nxt = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms_s ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_nxt = tms_s ? UPD_DR   : SH_DR;
      UPD_DR:   state_nxt = tms_s ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms_s ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms_s ? EX1_IR   : SH_IR;
      SH_IR:    state_nxt = tms_s ? EX1_IR   : SH_IR;
      EX1_IR:   state_nxt = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms_s ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_nxt = tms_s ? UPD_IR   : SH_IR;
      UPD_IR:   state_nxt = tms_s ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // Capture/shift/update act on the state being left, i.e. on the tck_rise
  // that exits CapXR/ShXR/UpdXR, which matches what a pad-clocked TAP does.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    idcode_sr_d = idcode_sr_q;
    user_sr_d   = user_sr_q;
    bypass_d    = bypass_q;
    tdo_d       = tdo_q;
    tdo_oe_d    = tdo_oe_q;
    capture     = 1'b0;
    update      = 1'b0;
    if (!trst_n_s) begin
      state_d     = TLR;
      ir_d        = IR_IDCODE;
      ir_sr_d     = '0;
      idcode_sr_d = '0;
      user_sr_d   = '0;
      bypass_d    = 1'b0;
      tdo_d       = 1'b0;
      tdo_oe_d    = 1'b0;
    end else if (tck_rise) begin
      state_d = state_nxt;
      case (state_q)
        CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
        SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
        UPD_IR: ir_d    = ir_sr_q;
        CAP_DR: begin
          case (dr_sel)
            SEL_IDCODE: idcode_sr_d = IDCODE_VAL;
            SEL_USER: begin
              user_sr_d = dr_capture_data_i;
              capture   = 1'b1;
            end
            default:    bypass_d = 1'b0;
          endcase
        end
        SH_DR: begin
          case (dr_sel)
            SEL_IDCODE: idcode_sr_d = {tdi_s, idcode_sr_q[31:1]};
            SEL_USER:   user_sr_d   = {tdi_s, user_sr_q[DR_WIDTH-1:1]};
            default:    bypass_d    = tdi_s;
          endcase
        end
        UPD_DR: update = (dr_sel == SEL_USER);
        default: ;
      endcase
      if (state_nxt == TLR) ir_d = IR_IDCODE;
    end else if (tck_fall) begin
      tdo_oe_d = (state_q == SH_IR) || (state_q == SH_DR);
      case (state_q)
        SH_IR: tdo_d = ir_sr_q[0];
        SH_DR: begin
          case (dr_sel)
            SEL_IDCODE: tdo_d = idcode_sr_q[0];
            SEL_USER:   tdo_d = user_sr_q[0];
            default:    tdo_d = bypass_q;
          endcase
        end
        default: tdo_d = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= TLR;
      ir_q        <= IR_IDCODE;
      ir_sr_q     <= '0;
      idcode_sr_q <= '0;
      user_sr_q   <= '0;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      idcode_sr_q <= idcode_sr_d;
      user_sr_q   <= user_sr_d;
      bypass_q    <= bypass_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
    end
  end

  assign jtag_tdo_o       = tdo_q;
  assign jtag_tdo_oe_o    = tdo_oe_q;
  assign tap_state_o      = state_q;
  assign ir_o             = ir_q;
  assign dr_capture_o     = capture;
  assign dr_update_o      = update;
  assign dr_update_data_o = user_sr_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Self-checking bench for jtag_tap_oversampled: a bit-banged JTAG host with
// expected TDO bits queued per shift and popped as each bit is observed.
module tb_jtag_tap_oversampled;

  localparam int HALF = 4;  // clk cycles per TCK half period

  logic        clk = 1'b0;
  logic        rst_i;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
  logic        jtag_tdo, jtag_tdo_oe;
  logic [3:0]  tap_state;
  logic [4:0]  ir;
  logic        dr_capture, dr_update;
  logic [40:0] dr_capture_data, dr_update_data;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cap_cnt  = 0;
  int   upd_cnt  = 0;
  logic [40:0] upd_seen = '0;
  logic [4:0]  ir_model = 5'h01;
  logic        exp_q [$];

  always #5 clk = ~clk;

  jtag_tap_oversampled dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .jtag_tck_i        (jtag_tck),
    .jtag_tms_i        (jtag_tms),
    .jtag_tdi_i        (jtag_tdi),
    .jtag_trst_ni      (jtag_trst_n),
    .jtag_tdo_o        (jtag_tdo),
    .jtag_tdo_oe_o     (jtag_tdo_oe),
    .tap_state_o       (tap_state),
    .ir_o              (ir),
    .dr_capture_o      (dr_capture),
    .dr_capture_data_i (dr_capture_data),
    .dr_update_o       (dr_update),
    .dr_update_data_o  (dr_update_data)
  );

  always @(negedge clk) begin
    if (dr_capture) cap_cnt++;
    if (dr_update) begin
      upd_cnt++;
      upd_seen = dr_update_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One TCK period; optionally pops an expected TDO bit just before the rise.
  task automatic tck_cycle(input logic tms, input logic tdi, input bit chk);
    logic exp;
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (HALF) @(negedge clk);
    if (chk) begin
      if (exp_q.size() == 0) begin
        check("tdo_queue_empty", 64'd1, 64'd0);
      end else begin
        exp = exp_q.pop_front();
        check("tdo", jtag_tdo, exp);
        check("tdo_oe", jtag_tdo_oe, 1);
      end
    end
    jtag_tck = 1'b1;
    repeat (HALF) @(negedge clk);
    jtag_tck = 1'b0;
  endtask

  // From Capture-XR, shift n bits (last one exits with TMS=1), expecting exp_bits on TDO.
  task automatic shift_bits(input int n, input logic [63:0] din, input logic [63:0] exp_bits);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_bits[i]);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, din[i], 1'b1);
  endtask

  task automatic rti_to_shdr();
    tck_cycle(1, 0, 0);  // SelDR
    tck_cycle(0, 0, 0);  // CapDR
    tck_cycle(0, 0, 0);  // ShDR (capture load)
  endtask

  task automatic load_ir(input logic [4:0] new_ir);
    tck_cycle(1, 0, 0);  // SelDR
    tck_cycle(1, 0, 0);  // SelIR
    tck_cycle(0, 0, 0);  // CapIR
    tck_cycle(0, 0, 0);  // ShIR
    check("state_shir", tap_state, 11);
    shift_bits(5, {59'd0, new_ir}, 64'h01);
    check("ir_hold_ex1ir", ir, ir_model);
    tck_cycle(1, 0, 0);  // UpdIR
    check("state_updir", tap_state, 15);
    check("ir_hold_updir", ir, ir_model);
    tck_cycle(0, 0, 0);  // RTI
    ir_model = new_ir;
    check("ir_updated", ir, ir_model);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0; jtag_trst_n = 1'b1;
    dr_capture_data = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (6) @(negedge clk);

    // Reset state
    check("rst_state", tap_state, 0);
    check("rst_ir", ir, 5'h01);
    check("rst_tdo_oe", jtag_tdo_oe, 0);
    check("rst_tdo", jtag_tdo, 0);
    check("rst_pulses", cap_cnt + upd_cnt, 0);

    // Bypass: IR=1F, 0xA5 comes back one TCK late, first bit 0
    tck_cycle(0, 0, 0);
    check("state_rti", tap_state, 1);
    load_ir(5'h1F);
    rti_to_shdr();
    check("state_shdr", tap_state, 4);
    shift_bits(9, 64'h0A5, 64'h14A);
    check("state_ex1dr", tap_state, 5);
    repeat (HALF) @(negedge clk);
    check("oe_after_shift", jtag_tdo_oe, 0);
    check("tdo_after_shift", jtag_tdo, 0);
    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);

    // IDCODE straight from reset
    for (int i = 0; i < 5; i++) tck_cycle(1, 0, 0);
    ir_model = 5'h01;
    check("tlr_state", tap_state, 0);
    check("tlr_ir", ir, 5'h01);
    tck_cycle(0, 0, 0);
    rti_to_shdr();
    shift_bits(32, 64'd0, 64'h10000DB3);
    tck_cycle(1, 0, 0);
    tck_cycle(0, 0, 0);
    check("no_pulses_yet", cap_cnt + upd_cnt, 0);

    // User DR capture / shift / update
    load_ir(5'h11);
    dr_capture_data = 41'h1_2345_6789_A;
    rti_to_shdr();
    check("cap_once", cap_cnt, 1);
    shift_bits(41, 64'h0_DEAD_BEEF_3, 64'h1_2345_6789_A);
    tck_cycle(1, 0, 0);  // UpdDR
    check("upd_not_on_entry", upd_cnt, 0);
    tck_cycle(0, 0, 0);  // RTI
    check("upd_once", upd_cnt, 1);
    check("upd_data", upd_seen, 41'h0_DEAD_BEEF_3);
    repeat (40) @(negedge clk);
    check("upd_no_repeat", upd_cnt, 1);

    // TRST mid-shift of the user DR
    rti_to_shdr();
    check("cap_twice", cap_cnt, 2);
    for (int i = 0; i < 10; i++) tck_cycle(0, i[0], 0);
    jtag_trst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("trst_state", tap_state, 0);
    check("trst_ir", ir, 5'h01);
    check("trst_oe", jtag_tdo_oe, 0);
    repeat (4) @(negedge clk);
    jtag_trst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("trst_no_update", upd_cnt, 1);

    // PauseIR -> TLR with five TMS=1 clocks
    tck_cycle(0, 0, 0);  // RTI
    tck_cycle(1, 0, 0);  // SelDR
    tck_cycle(1, 0, 0);  // SelIR
    tck_cycle(0, 0, 0);  // CapIR
    tck_cycle(1, 0, 0);  // Ex1IR
    tck_cycle(0, 0, 0);  // PauseIR
    check("state_pauseir", tap_state, 13);
    for (int i = 0; i < 5; i++) tck_cycle(1, 0, 0);
    check("pauseir_to_tlr", tap_state, 0);
    check("pauseir_ir", ir, 5'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
